// File: rtl/lcd_pattern_gen.sv
// Test-pattern source between the LCD timing stage and the panel pins.
// Re-times DE/syncs by one pixel strobe and generates RGB565 from a button-selected pattern.
module lcd_pattern_gen #(
  parameter int H_ACTIVE        = 480,
  parameter int V_ACTIVE        = 272,
  parameter int BAR_W           = 60,
  parameter int CHECK_LOG2      = 4,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int DEB_CYCLES      = 1000000
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       pix_ce,
  input  logic       in_de,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic       mode_btn,
  output logic       out_de,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic [4:0] out_r,
  output logic [5:0] out_g,
  output logic [4:0] out_b,
  output logic [1:0] mode,
  output logic [7:0] frame_cnt
);

  // Counters never narrower than 11/10 bits so the pattern bit-slices stay valid.
  localparam int XW = ($clog2(H_ACTIVE + 1) > 11) ? $clog2(H_ACTIVE + 1) : 11;
  localparam int YW = ($clog2(V_ACTIVE + 1) > 10) ? $clog2(V_ACTIVE + 1) : 10;
  localparam int BW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  localparam logic [15:0] C_WHITE   = 16'hFFFF;
  localparam logic [15:0] C_YELLOW  = 16'hFFE0;
  localparam logic [15:0] C_CYAN    = 16'h07FF;
  localparam logic [15:0] C_GREEN   = 16'h07E0;
  localparam logic [15:0] C_MAGENTA = 16'hF81F;
  localparam logic [15:0] C_RED     = 16'hF800;
  localparam logic [15:0] C_BLUE    = 16'h001F;
  localparam logic [15:0] C_BLACK   = 16'h0000;

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [BW-1:0] r_bar_cnt;
  logic [3:0]    r_bar_idx;
  logic          r_de_prev;
  logic          r_vs_prev;
  logic          r_btn_meta;
  logic          r_btn_sync;
  logic          r_btn_acc;
  logic [DW-1:0] r_deb_cnt;
  logic          r_pending;

  logic          w_vs_act;
  logic          w_frame_edge;
  logic          w_accept;
  logic          w_press;
  logic [15:0]   w_rgb;

  assign w_vs_act     = (SYNC_ACTIVE_LOW != 0) ? ~in_vsync : in_vsync;
  assign w_frame_edge = pix_ce & w_vs_act & ~r_vs_prev;

  // Position, bar tracking and frame counter; all advance on the pixel strobe only.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_x       <= '0;
      r_y       <= '0;
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
      r_de_prev <= 1'b0;
      r_vs_prev <= 1'b0;
      frame_cnt <= '0;
    end else if (pix_ce) begin
      r_de_prev <= in_de;
      r_vs_prev <= w_vs_act;
      if (in_de) begin
        if (r_x != '1) r_x <= r_x + 1'b1;
        if (r_bar_cnt == BW'(BAR_W - 1)) begin
          r_bar_cnt <= '0;
          if (r_bar_idx != '1) r_bar_idx <= r_bar_idx + 1'b1;
        end else begin
          r_bar_cnt <= r_bar_cnt + 1'b1;
        end
      end else begin
        r_x       <= '0;
        r_bar_cnt <= '0;
        r_bar_idx <= '0;
      end
      // Active vsync overrides a coincident DE falling edge.
      if (w_vs_act)
        r_y <= '0;
      else if (r_de_prev && !in_de && (r_y != '1))
        r_y <= r_y + 1'b1;
      if (w_frame_edge) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_comb begin
    w_rgb = C_BLACK;
    case (mode)
      2'd0: begin
        case (r_bar_idx)
          4'd0:    w_rgb = C_WHITE;
          4'd1:    w_rgb = C_YELLOW;
          4'd2:    w_rgb = C_CYAN;
          4'd3:    w_rgb = C_GREEN;
          4'd4:    w_rgb = C_MAGENTA;
          4'd5:    w_rgb = C_RED;
          4'd6:    w_rgb = C_BLUE;
          default: w_rgb = C_BLACK;
        endcase
      end
      2'd1:    w_rgb = (r_x[CHECK_LOG2] ^ r_y[CHECK_LOG2]) ? C_WHITE : C_BLACK;
      2'd2:    w_rgb = {r_x[8:4], r_y[8:3], frame_cnt[7:3]};
      default: w_rgb = (r_x[8:4] == frame_cnt[4:0]) ? C_WHITE : C_BLUE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_de    <= 1'b0;
      out_hsync <= SYNC_IDLE;
      out_vsync <= SYNC_IDLE;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else if (pix_ce) begin
      out_de    <= in_de;
      out_hsync <= in_hsync;
      out_vsync <= in_vsync;
      {out_r, out_g, out_b} <= in_de ? w_rgb : C_BLACK;
    end
  end

  // Button: 2-flop sync, then a level must persist DEB_CYCLES clocks to be accepted.
  assign w_accept = (r_btn_sync != r_btn_acc) && (r_deb_cnt == DW'(DEB_CYCLES - 1));
  assign w_press  = w_accept & r_btn_acc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_btn_meta <= 1'b1;
      r_btn_sync <= 1'b1;
      r_btn_acc  <= 1'b1;
      r_deb_cnt  <= '0;
    end else begin
      r_btn_meta <= mode_btn;
      r_btn_sync <= r_btn_meta;
      if (r_btn_sync == r_btn_acc) begin
        r_deb_cnt <= '0;
      end else if (w_accept) begin
        r_btn_acc <= r_btn_sync;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  // A press landing on the frame edge itself re-arms pending for the following frame.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mode      <= 2'd0;
      r_pending <= 1'b0;
    end else if (w_frame_edge) begin
      if (r_pending) mode <= mode + 2'd1;
      r_pending <= w_press;
    end else if (w_press) begin
      r_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Bench for lcd_pattern_gen: randomized strobe gaps and line widths checked against
// a per-pixel reference model derived from run lengths, edge counts and division.
module tb_lcd_pattern_gen;
  localparam int DEB   = 200;
  localparam int BAR_W = 60;

  logic       CLK = 1'b0, nRST = 1'b0, pix_ce = 1'b0;
  logic       in_de = 1'b0, in_hsync = 1'b1, in_vsync = 1'b1, mode_btn = 1'b1;
  logic       out_de, out_hsync, out_vsync;
  logic [4:0] out_r, out_b;
  logic [5:0] out_g;
  logic [1:0] mode;
  logic [7:0] frame_cnt;

  lcd_pattern_gen #(.DEB_CYCLES(DEB), .BAR_W(BAR_W)) u_dut (
    .CLK(CLK), .nRST(nRST), .pix_ce(pix_ce), .in_de(in_de), .in_hsync(in_hsync),
    .in_vsync(in_vsync), .mode_btn(mode_btn), .out_de(out_de), .out_hsync(out_hsync),
    .out_vsync(out_vsync), .out_r(out_r), .out_g(out_g), .out_b(out_b), .mode(mode),
    .frame_cnt(frame_cnt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;
  // Reference state: run length of DE, DE falls since vsync, frame count, mode, pending press.
  int m_x, m_y, m_fc, m_mode;
  bit m_pend, m_de_prev, m_vs_prev;
  logic e_de, e_hs, e_vs;
  logic [15:0] e_rgb;
  logic [15:0] bars [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int x, input int y, input int fc, input int md);
    int xs = (x > 2047) ? 2047 : x;
    int ys = (y > 1023) ? 1023 : y;
    case (md)
      0:       return (x / BAR_W < 8) ? bars[x / BAR_W] : 16'h0000;
      1:       return (((xs >> 4) ^ (ys >> 4)) & 1) != 0 ? 16'hFFFF : 16'h0000;
      2:       return {5'((xs >> 4) & 31), 6'((ys >> 3) & 63), 5'((fc >> 3) & 31)};
      default: return (((xs >> 4) & 31) == (fc & 31)) ? 16'hFFFF : 16'h001F;
    endcase
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_fc = 0; m_mode = 0; m_pend = 0; m_de_prev = 0; m_vs_prev = 0;
    e_de = 0; e_hs = 1; e_vs = 1; e_rgb = 0;
  endtask

  task automatic check_outputs();
    chk("de", out_de, e_de);
    chk("hsync", out_hsync, e_hs);
    chk("vsync", out_vsync, e_vs);
    chk("rgb", {out_r, out_g, out_b}, e_rgb);
    chk("mode", mode, m_mode);
    chk("fcnt", frame_cnt, m_fc);
  endtask

  task automatic pixel(input logic de, input logic hs, input logic vs, input int gap);
    bit vs_act;
    vs_act = !vs;
    @(negedge CLK);
    in_de = de; in_hsync = hs; in_vsync = vs; pix_ce = 1'b1;
    e_rgb = de ? pat(m_x, m_y, m_fc, m_mode) : 16'h0000;
    e_de = de; e_hs = hs; e_vs = vs;
    if (vs_act && !m_vs_prev) begin
      m_fc = (m_fc + 1) % 256;
      if (m_pend) begin m_mode = (m_mode + 1) % 4; m_pend = 0; end
    end
    if (vs_act) m_y = 0;
    else if (m_de_prev && !de) m_y++;
    m_x = de ? m_x + 1 : 0;
    m_de_prev = de; m_vs_prev = vs_act;
    @(negedge CLK);
    pix_ce = 1'b0;
    check_outputs();
    if (gap > 0) begin
      // Inputs wander while the strobe is low; nothing may move.
      for (int g = 0; g < gap; g++) begin
        @(negedge CLK);
        in_de = 1'($urandom); in_hsync = 1'($urandom); in_vsync = 1'($urandom);
      end
      check_outputs();
    end
  endtask

  function automatic int rg();
    return int'($urandom_range(0, 2));
  endfunction

  task automatic line(input int ln, input int width, input int frz_at);
    int md;
    pixel(0, 0, 1, rg()); pixel(0, 0, 1, rg());
    pixel(0, 1, 1, rg()); pixel(0, 1, 1, rg());
    md = m_mode;
    for (int i = 0; i < width; i++) begin
      pixel(1, 1, 1, (i == frz_at) ? 50 : rg());
      if (md == 0 && i == 0)   chk("bar_x0_white", {out_r, out_g, out_b}, 16'hFFFF);
      if (md == 0 && i == 60)  chk("bar_x60_yellow", {out_r, out_g, out_b}, 16'hFFE0);
      if (md == 0 && i == 420) chk("bar_x420_black", {out_r, out_g, out_b}, 16'h0000);
      if (md == 1 && ln == 0 && i == 16)  chk("chk_16_0_white", {out_r, out_g, out_b}, 16'hFFFF);
      if (md == 1 && ln == 0 && i == 0)   chk("chk_0_0_black", {out_r, out_g, out_b}, 16'h0000);
      if (md == 1 && ln == 16 && i == 16) chk("chk_16_16_black", {out_r, out_g, out_b}, 16'h0000);
    end
  endtask

  task automatic press();
    @(negedge CLK); mode_btn = 1'b0;
    repeat (DEB + 10) @(negedge CLK);
    mode_btn = 1'b1;
    repeat (DEB + 10) @(negedge CLK);
    m_pend = 1;
  endtask

  task automatic glitch();
    @(negedge CLK); mode_btn = 1'b0;
    repeat (DEB / 2) @(negedge CLK);
    mode_btn = 1'b1;
    repeat (DEB + 10) @(negedge CLK);
  endtask

  task automatic frame(input int nl, input int width, input int frz_ln, input int frz_at,
                       input int press_ln, input int presses);
    pixel(0, 1, 0, rg()); pixel(0, 1, 0, rg()); pixel(0, 1, 0, rg());
    pixel(0, 1, 1, rg()); pixel(0, 1, 1, rg());
    for (int ln = 0; ln < nl; ln++) begin
      line(ln, width, (ln == frz_ln) ? frz_at : -1);
      if (ln == press_ln) for (int p = 0; p < presses; p++) press();
    end
  endtask

  task automatic short_frame();
    pixel(0, 1, 0, 0);
    pixel(0, 1, 1, 0);
  endtask

  initial begin
    model_reset();
    #23;
    chk("rst_de", out_de, 1'b0);
    chk("rst_hsync", out_hsync, 1'b1);
    chk("rst_vsync", out_vsync, 1'b1);
    chk("rst_rgb", {out_r, out_g, out_b}, 16'h0000);
    chk("rst_mode", mode, 2'd0);
    chk("rst_fcnt", frame_cnt, 8'd0);
    @(negedge CLK); nRST = 1'b1;

    // Colour bars with a 50-clock strobe stall mid-line, then a press mid-frame.
    frame(2, 480, 0, 200, 1, 1);
    chk("mode_held_until_frame", mode, 2'd0);
    frame(17, 20, -1, -1, -1, 0);
    chk("mode_seq_1", mode, 2'd1);
    glitch();
    frame(3, 40, -1, -1, -1, 0);
    chk("glitch_no_change", mode, 2'd1);

    press();
    frame(10, int'($urandom_range(100, 480)), -1, -1, -1, 0);
    chk("mode_seq_2", mode, 2'd2);
    press();
    frame(3, int'($urandom_range(100, 480)), -1, -1, -1, 0);
    chk("mode_seq_3", mode, 2'd3);
    press();
    frame(2, int'($urandom_range(100, 480)), -1, -1, -1, 0);
    chk("mode_seq_0", mode, 2'd0);
    // Two presses inside one frame collapse into a single advance.
    frame(2, 30, 0, -1, 0, 2);
    frame(1, 10, -1, -1, -1, 0);
    chk("double_press_one_step", mode, 2'd1);

    while (m_fc != 255) short_frame();
    chk("fcnt_255", frame_cnt, 8'd255);
    short_frame();
    chk("fcnt_wrap", frame_cnt, 8'd0);
    short_frame();

    // Asynchronous reset in the middle of an active line.
    pixel(0, 0, 1, 0);
    for (int i = 0; i < 30; i++) pixel(1, 0, 1, rg());
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst_de", out_de, 1'b0);
    chk("mid_rst_hsync", out_hsync, 1'b1);
    chk("mid_rst_vsync", out_vsync, 1'b1);
    chk("mid_rst_rgb", {out_r, out_g, out_b}, 16'h0000);
    chk("mid_rst_mode", mode, 2'd0);
    chk("mid_rst_fcnt", frame_cnt, 8'd0);
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    frame(3, 64, -1, -1, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lcd_pattern_gen.md
Name: lcd_pattern_gen

Overview:
Test-pattern source placed directly downstream of the LCD timing stage, ahead of the LCD output pins.
- Consumes DE/HSYNC/VSYNC from the timing stage.
- Produces RGB565 pixel data and copies of the sync signals, delayed to line up with that data.
- A debounced board button selects one of four patterns. The new selection is applied at the next frame boundary.
- Runs on the system clock. A one-cycle pixel strobe marks each pixel.

Parameters:
H_ACTIVE, 480, active pixels per line (x counter is 11 bits)
V_ACTIVE, 272, active lines per frame (y counter is 10 bits)
BAR_W, 60, colour-bar width in pixels
CHECK_LOG2, 4, checker square size = 2^CHECK_LOG2 pixels
SYNC_ACTIVE_LOW, 1, sync input/output polarity (1 = active-low)
DEB_CYCLES, 1000000, number of stable CLK cycles before a button level is accepted

Ports:
CLK  in  1  system clock
nRST  in  1  asynchronous reset, active-low
pix_ce  in  1  pixel strobe: one CLK cycle high per pixel
in_de  in  1  data-enable from the timing stage
in_hsync  in  1  hsync from the timing stage
in_vsync  in  1  vsync from the timing stage
mode_btn  in  1  raw push button, active-low, asynchronous
out_de  out  1  delayed DE
out_hsync  out  1  delayed hsync
out_vsync  out  1  delayed vsync
out_r  out  5  red
out_g  out  6  green
out_b  out  5  blue
mode  out  2  pattern currently applied
frame_cnt  out  8  frame counter

Behaviour:
Reset (nRST low, asynchronous):
- out_de, out_r, out_g, out_b, mode, frame_cnt, all counters = 0.
- out_hsync and out_vsync = inactive level (1 when SYNC_ACTIVE_LOW=1).
- Debouncer state = released.

Pixel pipeline:
- Advances only on CLK edges where pix_ce=1. All pixel-path outputs hold while pix_ce=0.
- Latency is exactly one pix_ce. out_de, out_hsync, out_vsync and RGB are the registered versions of the inputs sampled at the previous pix_ce.
- RGB = 0 whenever the registered DE is 0.

Counters (evaluated at each pix_ce):
- x:
  - in_de=1 → x increments, saturating at 2047.
  - in_de=0 → x = 0.
- y:
  - Increments on a DE falling edge (previous DE=1, in_de=0).
  - Set to 0 while vsync is active.
  - Saturates at 1023.
- Colour-bar tracking uses no divider. bar_cnt counts 0..BAR_W-1 and bar_idx increments each time bar_cnt wraps. Both are cleared whenever in_de=0.
- frame_cnt increments on the vsync inactive→active edge and wraps 255→0.
- Simultaneous events: if a DE falling edge and active vsync occur on the same pix_ce, vsync wins and y = 0.

Patterns (computed from the current x, y, bar_idx, frame_cnt; registered with DE):
- mode 0, colour bars. bar_idx 0..7 = white, yellow, cyan, green, magenta, red, blue, black. bar_idx > 7 = black.
  - White = {31,63,31}, yellow = {31,63,0}, cyan = {0,63,31}, green = {0,63,0}.
  - Magenta = {31,0,31}, red = {31,0,0}, blue = {0,0,31}.
- mode 1, checkerboard: white if x[CHECK_LOG2] XOR y[CHECK_LOG2], else black.
- mode 2, gradient: r = x[8:4], g = y[8:3], b = frame_cnt[7:3].
- mode 3, moving bar: white if x[8:4] == frame_cnt[4:0], else blue {0,0,31}.

Mode button:
- mode_btn passes through a 2-flop synchronizer on CLK.
- Debounce: a counter runs while the synchronized level differs from the accepted level. It clears whenever the two match. On reaching DEB_CYCLES-1 the accepted level takes the new value.
- An accepted high→low transition sets a pending request; pending is a single flag, so multiple presses collapse to one.
- On the next vsync inactive→active edge: mode increments (wrapping 3→0) and pending clears.
- A press accepted on the same cycle as the frame edge is applied at the following frame.
- Debounce logic runs every CLK, independent of pix_ce.

Reset mid-frame: all state returns to reset values immediately. Output restarts cleanly once nRST is released and the next pix_ce arrives. There is no requirement to wait for a frame boundary.

Test Plan:
- Reset, then pix_ce every 10th CLK and a 480x272 timing stream → first active pixel has RGB = {31,63,31}. Pixel at x=60 is yellow; x=420 is black. Sync outputs lag the inputs by exactly one pix_ce.
- pix_ce held low for 50 CLK mid-line → all outputs are frozen, x does not advance, and no pixel is lost or duplicated after pix_ce resumes.
- mode 1 → pixel (x=16, y=0) is white, (0,0) is black, (16,16) is black.
- mode_btn low for DEB_CYCLES+10 CLK mid-frame → mode stays 0 until the next vsync active edge, then mode = 1. A 100-cycle glitch produces no change.
- Four accepted presses, each across its own frame → mode sequence 1, 2, 3, 0. Two presses within one frame advance mode by 1 only.
- 256 vsync pulses → frame_cnt wraps 255→0. Assert nRST mid-line → out_de = 0, out_hsync = out_vsync = 1, mode = 0, frame_cnt = 0 on the same CLK edge.
